// File: rtl/axi_crossbar_rd_resp_if.sv
// AXI read-data (R) channel bundle used on both sides of the crossbar read-response path.
// The master modport drives the beat payload and valid; the slave modport drives ready.
interface axi_crossbar_rd_resp_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 8,
  parameter int RUSER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]    rid;
  logic [DATA_WIDTH-1:0]  rdata;
  logic [1:0]             rresp;
  logic                   rlast;
  logic [RUSER_WIDTH-1:0] ruser;
  logic                   rvalid;
  logic                   rready;

  modport master (
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );

  modport slave (
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_crossbar_rd_resp.sv
// Crossbar read-response return path for one slave interface.
// Merges the routed R stream with locally generated DECERR bursts for reads that failed
// address decode, one whole burst at a time, and pulses a completion with the burst ID once
// the last beat leaves on the slave-side R channel.
// Optional feature macro: AXI_CROSSBAR_RD_RESP_SKID_EN -- registered 2-entry output skid
// buffer (1-cycle latency, registered upstream ready). Default: combinational output path.
module axi_crossbar_rd_resp #(
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 8,
  parameter int RUSER_EN    = 0,
  parameter int RUSER_WIDTH = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ID_WIDTH-1:0] s_rc_id,
  input  logic [7:0]          s_rc_len,
  input  logic                s_rc_valid,
  output logic                s_rc_ready,
  axi_crossbar_rd_resp_if.slave  s_axi,
  axi_crossbar_rd_resp_if.master m_axi,
  output logic [ID_WIDTH-1:0] m_cpl_id,
  output logic                m_cpl_valid
);

  typedef enum logic [1:0] {IDLE, FWD, DERR} state_t;
  typedef enum logic {PRIO_ROUTED, PRIO_DERR} prio_t;

  state_t                 state;
  prio_t                  prio;
  logic [7:0]             cnt;
  logic [ID_WIDTH-1:0]    derr_id;

  logic                   pick_fwd;
  logic                   pick_derr;
  logic                   contend;
  logic                   room;
  logic                   take;
  logic                   src_valid;
  logic [ID_WIDTH-1:0]    src_id;
  logic [DATA_WIDTH-1:0]  src_data;
  logic [1:0]             src_resp;
  logic                   src_last;
  logic [RUSER_WIDTH-1:0] src_user;

  // Arbitration between a waiting routed burst and a waiting decode-error command.
  always_comb begin
    contend   = s_axi.rvalid && s_rc_valid;
    pick_fwd  = s_axi.rvalid && (!s_rc_valid || prio == PRIO_ROUTED);
    pick_derr = s_rc_valid && !pick_fwd;
  end

  // Selected source beat: routed beat passes through, DECERR beats are synthesised.
  always_comb begin
    src_valid = 1'b0;
    src_id    = '0;
    src_data  = '0;
    src_resp  = 2'b00;
    src_last  = 1'b0;
    src_user  = '0;
    case (state)
      FWD: begin
        src_valid = s_axi.rvalid;
        src_id    = s_axi.rid;
        src_data  = s_axi.rdata;
        src_resp  = s_axi.rresp;
        src_last  = s_axi.rlast;
        src_user  = (RUSER_EN != 0) ? s_axi.ruser : '0;
      end
      DERR: begin
        src_valid = 1'b1;
        src_id    = derr_id;
        src_resp  = 2'b11;
        src_last  = (cnt == 8'd0);
      end
      default: ;
    endcase
    take = src_valid && room;
  end

  // The command is consumed in the very cycle the FSM commits to the DECERR burst.
  assign s_rc_ready   = (state == IDLE) && pick_derr;
  assign s_axi.rready = (state == FWD) && room;

  // Burst sequencer. Priority only rotates when both sources competed for the same slot,
  // so an uncontended grant never disturbs the round-robin order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      prio    <= PRIO_ROUTED;
      cnt     <= 8'd0;
      derr_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (contend) prio <= (prio == PRIO_ROUTED) ? PRIO_DERR : PRIO_ROUTED;
          if (pick_fwd) begin
            state <= FWD;
          end else if (pick_derr) begin
            state   <= DERR;
            derr_id <= s_rc_id;
            cnt     <= s_rc_len;
          end
        end
        FWD: begin
          if (take && s_axi.rlast) state <= IDLE;
        end
        DERR: begin
          if (take) begin
            if (cnt == 8'd0) state <= IDLE;
            else             cnt   <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXI_CROSSBAR_RD_RESP_SKID_EN
  localparam int BW = ID_WIDTH + DATA_WIDTH + 2 + 1 + RUSER_WIDTH;

  logic [BW-1:0] skid_mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    skid_cnt;
  logic          skid_full;
  logic          pop;

  assign skid_full    = (skid_cnt == 2'd2);
  assign room         = !skid_full;
  assign pop          = m_axi.rvalid && m_axi.rready;
  assign m_axi.rvalid = (skid_cnt != 2'd0);
  assign {m_axi.rid, m_axi.rdata, m_axi.rresp, m_axi.rlast, m_axi.ruser} = skid_mem[rd_ptr];

  // Two-entry output queue; upstream ready depends only on registered occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) skid_mem[i] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      skid_cnt <= 2'd0;
    end else begin
      if (take) begin
        skid_mem[wr_ptr] <= {src_id, src_data, src_resp, src_last, src_user};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({take, pop})
        2'b10:   skid_cnt <= skid_cnt + 2'd1;
        2'b01:   skid_cnt <= skid_cnt - 2'd1;
        default: ;
      endcase
    end
  end
`else
  assign room         = m_axi.rready;
  assign m_axi.rvalid = src_valid;
  assign m_axi.rid    = src_id;
  assign m_axi.rdata  = src_data;
  assign m_axi.rresp  = src_resp;
  assign m_axi.rlast  = src_last;
  assign m_axi.ruser  = src_user;
`endif

  // Completion pulse one cycle after the last beat of a burst is accepted downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cpl_valid <= 1'b0;
      m_cpl_id    <= '0;
    end else begin
      m_cpl_valid <= m_axi.rvalid && m_axi.rready && m_axi.rlast;
      if (m_axi.rvalid && m_axi.rready && m_axi.rlast) m_cpl_id <= m_axi.rid;
    end
  end

endmodule

// File: tb/tb_axi_crossbar_rd_resp.sv
// Self-checking bench for axi_crossbar_rd_resp. A reference model builds the expected
// beat stream and completion list from the burst-level rules; a monitor records what
// actually crossed the slave-side R handshake and checks stall stability.
module tb_axi_crossbar_rd_resp;
  localparam int DW = 32;
  localparam int IW = 8;
  localparam int UW = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [IW-1:0] rc_id;
  logic [7:0]    rc_len;
  logic          rc_valid;
  logic          rc_ready;
  logic [IW-1:0] cpl_id;
  logic          cpl_valid;

  axi_crossbar_rd_resp_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .RUSER_WIDTH(UW)) s_if ();
  axi_crossbar_rd_resp_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .RUSER_WIDTH(UW)) m_if ();

  axi_crossbar_rd_resp #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .RUSER_EN(0), .RUSER_WIDTH(UW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_rc_id     (rc_id),
    .s_rc_len    (rc_len),
    .s_rc_valid  (rc_valid),
    .s_rc_ready  (rc_ready),
    .s_axi       (s_if),
    .m_axi       (m_if),
    .m_cpl_id    (cpl_id),
    .m_cpl_valid (cpl_valid)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [63:0]   exp_q[$];
  logic [63:0]   obs_q[$];
  logic [63:0]   rt_q[$];
  logic [IW-1:0] exp_cpl[$];
  logic [IW-1:0] obs_cpl[$];
  logic          rr_random = 1'b0;
  logic          model_prio_derr = 1'b0;

  function automatic logic [63:0] pack(logic [7:0] id, logic [31:0] d, logic [1:0] r, logic l);
    return {21'd0, id, d, r, l};
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a routed burst comes out unchanged, a DECERR burst is len+1 zero beats.
  task automatic model_routed();
    foreach (rt_q[i]) exp_q.push_back(rt_q[i]);
    exp_cpl.push_back(rt_q[rt_q.size()-1][42:35]);
  endtask

  task automatic model_derr(logic [7:0] id, logic [7:0] len);
    for (int i = 0; i <= int'(len); i++) exp_q.push_back(pack(id, 32'd0, 2'b11, i == int'(len)));
    exp_cpl.push_back(id);
  endtask

  task automatic make_routed(logic [7:0] id, int n);
    rt_q.delete();
    for (int i = 0; i < n; i++)
      rt_q.push_back(pack(id, $urandom, 2'($urandom_range(0, 3)), i == n - 1));
  endtask

  task automatic drive_routed();
    int   t;
    logic hs;
    @(negedge clk);
    foreach (rt_q[i]) begin
      s_if.rvalid = 1'b1;
      s_if.rid    = rt_q[i][42:35];
      s_if.rdata  = rt_q[i][34:3];
      s_if.rresp  = rt_q[i][2:1];
      s_if.rlast  = rt_q[i][0];
      t = 0;
      do begin
        #4 hs = s_if.rready;
        @(negedge clk);
        t++;
      end while (!hs && t < 3000);
      if (!hs) begin
        check("routed_hs_timeout", hs, 1);
        break;
      end
    end
    s_if.rvalid = 1'b0;
    s_if.rlast  = 1'b0;
  endtask

  task automatic drive_rc(logic [7:0] id, logic [7:0] len);
    int   t;
    logic hs;
    @(negedge clk);
    rc_valid = 1'b1;
    rc_id    = id;
    rc_len   = len;
    t = 0;
    do begin
      #4 hs = rc_ready;
      @(negedge clk);
      t++;
    end while (!hs && t < 3000);
    if (!hs) check("rc_hs_timeout", hs, 1);
    rc_valid = 1'b0;
  endtask

  task automatic drain_compare(string tag);
    int t = 0;
    while (obs_q.size() < exp_q.size() && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check({tag, "_nbeats"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "_beat"}, obs_q[i], exp_q[i]);
    check({tag, "_ncpl"}, obs_cpl.size(), exp_cpl.size());
    for (int i = 0; i < exp_cpl.size() && i < obs_cpl.size(); i++)
      check({tag, "_cpl_id"}, obs_cpl[i], exp_cpl[i]);
    exp_q.delete();
    obs_q.delete();
    exp_cpl.delete();
    obs_cpl.delete();
  endtask

  // Downstream ready: always 1 or a 50% coin flip per cycle.
  initial begin
    m_if.rready = 1'b1;
    forever begin
      @(negedge clk);
      m_if.rready = rr_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: records accepted beats and completions, checks payload hold while stalled.
  initial begin
    logic        prev_stall;
    logic [63:0] prev_beat;
    logic [63:0] cur;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      #4;
      cur = pack(m_if.rid, m_if.rdata, m_if.rresp, m_if.rlast);
      if (rst_n) begin
        if (prev_stall) begin
          check("stall_valid_held", m_if.rvalid, 1);
          check("stall_beat_held", cur, prev_beat);
        end
        if (m_if.rvalid && m_if.rready) obs_q.push_back(cur);
        if (cpl_valid) obs_cpl.push_back(cpl_id);
        prev_stall = m_if.rvalid && !m_if.rready;
        prev_beat  = cur;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] id;
    rst_n       = 1'b0;
    rc_valid    = 1'b0;
    rc_id       = '0;
    rc_len      = '0;
    s_if.rvalid = 1'b0;
    s_if.rid    = '0;
    s_if.rdata  = '0;
    s_if.rresp  = '0;
    s_if.rlast  = 1'b0;
    s_if.ruser  = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_rc_ready", rc_ready, 0);
    check("rst_s_rready", s_if.rready, 0);
    check("rst_m_rvalid", m_if.rvalid, 0);
    check("rst_cpl_valid", cpl_valid, 0);
    check("rst_cpl_id", cpl_id, 0);
    check("rst_m_beat", pack(m_if.rid, m_if.rdata, m_if.rresp, m_if.rlast), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: routed 4-beat burst, ID 0x5
    make_routed(8'h05, 4);
    model_routed();
    drive_routed();
    drain_compare("t1_routed");

    // 2: DECERR id 0x3 len 3
    model_derr(8'h03, 8'd3);
    drive_rc(8'h03, 8'd3);
    drain_compare("t2_derr");

    // 3: DECERR len 0 then len 255
    model_derr(8'h11, 8'd0);
    drive_rc(8'h11, 8'd0);
    model_derr(8'h12, 8'd255);
    drive_rc(8'h12, 8'd255);
    drain_compare("t3_derr_len");

    // 4: simultaneous requests twice; priority rotates on each contention
    for (int rep = 0; rep < 2; rep++) begin
      make_routed(8'h21 + 8'(rep), 3);
      if (model_prio_derr) begin
        model_derr(8'h31 + 8'(rep), 8'd2);
        model_routed();
      end else begin
        model_routed();
        model_derr(8'h31 + 8'(rep), 8'd2);
      end
      model_prio_derr = !model_prio_derr;
      fork
        drive_routed();
        drive_rc(8'h31 + 8'(rep), 8'd2);
      join
      drain_compare("t4_arb");
    end

    // 5: 8-beat routed burst under random backpressure
    rr_random = 1'b1;
    make_routed(8'h44, 8);
    model_routed();
    drive_routed();
    drain_compare("t5_backpressure");

    // Random sequential mix of both sources under random backpressure
    for (int k = 0; k < 8; k++) begin
      id = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        make_routed(id, int'($urandom_range(1, 6)));
        model_routed();
        drive_routed();
      end else begin
        rc_len = 8'($urandom_range(0, 7));
        model_derr(id, rc_len);
        drive_rc(id, rc_len);
      end
    end
    drain_compare("rand_mix");
    rr_random = 1'b0;
    repeat (2) @(negedge clk);

    // 6: async reset in the middle of a 4-beat DECERR burst
    begin
      int t = 0;
      drive_rc(8'h09, 8'd3);
      while (obs_q.size() < 2 && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("t6_reached_beat2", obs_q.size() >= 2, 1);
      #1 rst_n = 1'b0;
      #1;
      check("t6_rst_m_rvalid", m_if.rvalid, 0);
      check("t6_rst_m_beat", pack(m_if.rid, m_if.rdata, m_if.rresp, m_if.rlast), 0);
      check("t6_rst_rc_ready", rc_ready, 0);
      check("t6_rst_s_rready", s_if.rready, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("t6_no_cpl", obs_cpl.size(), 0);
      exp_q.delete();
      obs_q.delete();
      exp_cpl.delete();
      obs_cpl.delete();
      model_prio_derr = 1'b0;
      model_derr(8'h04, 8'd1);
      drive_rc(8'h04, 8'd1);
      drain_compare("t6_after_reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
